// File: rtl/fc_pkg.sv
// fc_pkg: shared defaults, FSM encoding and address helper for the FC feature-map reader.
package fc_pkg;

    localparam int NUM_OUT_DEF  = 10;
    localparam int FM_WORDS_DEF = 48;
    localparam int ACC_W_DEF    = 32;
    localparam int MAC_W        = 19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } fc_state_e;

    // Weight rows are stored neuron-major, FM_WORDS words per neuron; wraps at 16 bits.
    function automatic logic [15:0] w_word_addr(input logic [15:0] neuron, input logic [15:0] idx,
                                                input int words);
        return neuron * 16'(words) + idx;
    endfunction

endpackage

// File: rtl/fc_mac8.sv
// fc_mac8: combinational 8-lane signed 8x8 dot product, 19-bit signed result.
module fc_mac8
    import fc_pkg::*;
(
    input  logic [63:0]              fm_i,
    input  logic [63:0]              w_i,
    output logic signed [MAC_W-1:0]  dot_o
);

    logic signed [MAC_W-1:0] sum;
    logic signed [15:0]      prod;

    always_comb begin
        sum  = '0;
        prod = '0;
        for (int k = 0; k < 8; k++) begin
            prod = 16'(signed'(fm_i[8*k +: 8])) * 16'(signed'(w_i[8*k +: 8]));
            sum  = sum + MAC_W'(prod);
        end
        dot_o = sum;
    end

endmodule

// File: rtl/fc_fm_reader.sv
// fc_fm_reader: streams the feature map against each neuron's weight row and
// emits one signed dot-product result per neuron.
module fc_fm_reader
    import fc_pkg::*;
#(
    parameter int NUM_OUT  = NUM_OUT_DEF,
    parameter int FM_WORDS = FM_WORDS_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_fc_start,
    output logic [15:0]             o_fc_fm_addr,
    input  logic [63:0]             i_fc_fm_data,
    output logic [15:0]             o_w_addr,
    input  logic [63:0]             i_w_data,
    output logic signed [ACC_W-1:0] o_fc_result,
    output logic                    o_fc_valid,
    output logic                    o_fc_done,
    output logic                    o_busy
);

    localparam logic [15:0] LAST_IDX    = 16'(FM_WORDS - 1);
    localparam logic [15:0] LAST_NEURON = 16'(NUM_OUT - 1);

    fc_state_e               state_q, state_d;
    logic [15:0]             idx_q, idx_d;
    logic [15:0]             neuron_q, neuron_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] result_q, result_d;
    logic                    vld_q;
    logic signed [MAC_W-1:0] dot;

    fc_mac8 u_mac (
        .fm_i  (i_fc_fm_data),
        .w_i   (i_w_data),
        .dot_o (dot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            neuron_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            neuron_q <= neuron_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            vld_q    <= (state_q == ST_READ);
        end
    end

    // vld_q marks the cycle where memory returns the word addressed one cycle earlier.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        neuron_d = neuron_q;
        result_d = result_q;
        acc_d    = vld_q ? acc_q + ACC_W'(dot) : acc_q;
        case (state_q)
            ST_IDLE: begin
                if (i_fc_start) begin
                    neuron_d = '0;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                idx_d   = idx_q + 16'd1;
                state_d = (idx_q == LAST_IDX) ? ST_DRAIN : ST_READ;
            end
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT: begin
                result_d = acc_q;
                acc_d    = '0;
                if (neuron_q == LAST_NEURON) begin
                    state_d = ST_DONE;
                end else begin
                    neuron_d = neuron_q + 16'd1;
                    idx_d    = '0;
                    state_d  = ST_READ;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_fc_fm_addr = (state_q == ST_READ) ? (idx_q << 3) : '0;
    assign o_w_addr     = (state_q == ST_READ) ? w_word_addr(neuron_q, idx_q, FM_WORDS) : '0;
    assign o_fc_result  = (state_q == ST_OUT) ? acc_q : result_q;
    assign o_fc_valid   = (state_q == ST_OUT);
    assign o_fc_done    = (state_q == ST_DONE);
    assign o_busy       = (state_q != ST_IDLE);

endmodule
